// File: rtl/dm_responder.sv
// Handshaked word-organised data memory with byte-enable stores and programmable response latency.
// Optional store logging is compiled in when DM_WRITE_LOG_EN is defined.
module dm_responder #(
   parameter int unsigned DEPTH   = 3072,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH];

   logic            accept;
   logic            fire;
   logic            acc_we;
   logic [31:0]     acc_addr;
   logic [31:0]     acc_wdata;
   logic [3:0]      acc_be;
   logic            acc_err;
   logic [IdxW-1:0] acc_idx;
   logic [31:0]     cur_word;
   logic [31:0]     merged;

   assign accept = (state_q == StIdle) && req_valid;
   // With LATENCY=1 the access happens on the acceptance edge itself, straight from the inputs.
   assign fire   = (LATENCY == 1) ? accept : ((state_q == StWait) && (cnt_q == 4'd1));

   always_comb begin
      if (state_q == StIdle) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
      acc_err  = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
      acc_idx  = acc_addr[IdxW+1:2];
      cur_word = acc_err ? 32'd0 : mem[acc_idx];
      merged   = cur_word;
      for (int i = 0; i < 4; i++) begin
         if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = (LATENCY == 1) ? StResp : StWait;
         StWait:  if (cnt_q == 4'd1) state_d = StResp;
         StResp:  if (resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = (state_q == StResp);
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q   <= 4'(LATENCY - 1);
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end else if (state_q == StWait) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (fire) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_we) ? 32'd0 : cur_word;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else if (fire && acc_we && !acc_err) begin
         mem[acc_idx] <= merged;
      end
   end

`ifdef DM_WRITE_LOG_EN
   logic [31:0] pc_q;
   logic [31:0] acc_pc;

   assign acc_pc = (state_q == StIdle) ? req_pc : pc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       pc_q <= 32'd0;
      else if (accept) pc_q <= req_pc;
   end

   always_ff @(posedge clk) begin
      if (!reset && fire && acc_we && !acc_err && (acc_be != 4'd0)) begin
         $display("@%h: *%h <= %h", acc_pc, {acc_addr[31:2], 2'b00}, merged);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=2 instance checked via a response monitor,
// plus a LATENCY=1 instance checked for back-to-back throughput.
module tb_dm_responder;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata, req_pc;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        r1_valid, r1_ready, r1_we;
   logic [31:0] r1_addr, r1_wdata, r1_pc;
   logic [3:0]  r1_be;
   logic        s1_valid, s1_err;
   logic        s1_ready = 1'b1;
   logic [31:0] s1_rdata;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic        prev_rv = 1'b0;
   logic [32:0] exp_q [$];
   logic [32:0] mon_e;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH(3072), .LATENCY(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dm_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (r1_valid),
      .req_ready  (r1_ready),
      .req_we     (r1_we),
      .req_addr   (r1_addr),
      .req_wdata  (r1_wdata),
      .req_be     (r1_be),
      .req_pc     (r1_pc),
      .resp_valid (s1_valid),
      .resp_ready (s1_ready),
      .resp_rdata (s1_rdata),
      .resp_err   (s1_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: latency counted from the cycle the request handshake is seen to the cycle
   // resp_valid is first seen; responses are popped when the handshake is presented.
   always @(negedge clk) begin
      if (reset) begin
         prev_rv = 1'b0;
      end else begin
         if (req_valid && req_ready) acc_cyc = cyc;
         if (resp_valid && !prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
         prev_rv = resp_valid;
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rdata", resp_rdata, mon_e[31:0]);
               chk("err", {31'b0, resp_err}, {31'b0, mon_e[32]});
            end
         end
      end
   end

   // Entered and left at #1 after a rising edge with the DUT idle.
   task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input logic ee,
                       input int hold);
      int n;
      exp_q.push_back({ee, er});
      req_we     = we;
      req_addr   = a;
      req_wdata  = wd;
      req_be     = be;
      req_pc     = 32'h0000_1000 + a;
      req_valid  = 1'b1;
      resp_ready = (hold == 0);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin n++; @(negedge clk); end
      chk("accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      // Scrambled request inputs must have no effect once accepted.
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'h0000_0008;
      req_wdata = 32'hFFFF_FFFF;
      req_be    = 4'hF;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 30) begin n++; @(negedge clk); end
      chk("resp_seen", {31'b0, resp_valid}, 32'd1);
      if (hold > 0) begin
         req_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, er);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
         end
         @(posedge clk); #1;
         req_valid  = 1'b0;
         resp_ready = 1'b1;
         @(negedge clk);
         chk("bp_valid_end", {31'b0, resp_valid}, 32'd1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("ready_after_hs", {31'b0, req_ready}, 32'd1);
      end
      @(posedge clk); #1;
   endtask

   task automatic set_u1(input int k);
      r1_pc = 32'h0000_3000 + 32'(4 * k);
      case (k)
         0: begin r1_we = 1'b1; r1_addr = 32'h4; r1_wdata = 32'h0000_0005; r1_be = 4'hF; r1_pc = 32'h0000_3000; end
         1: begin r1_we = 1'b0; r1_addr = 32'h4; r1_wdata = 32'hFFFF_FFFF; r1_be = 4'hF; end
         2: begin r1_we = 1'b1; r1_addr = 32'h4; r1_wdata = 32'h0000_0A00; r1_be = 4'b0010; end
         default: begin r1_we = 1'b0; r1_addr = 32'h4; r1_wdata = 32'h0; r1_be = 4'h0; end
      endcase
   endtask

   function automatic logic [31:0] exp_u1(input int k);
      case (k)
         1:       return 32'h0000_0005;
         3:       return 32'h0000_0A05;
         default: return 32'h0000_0000;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; req_pc = '0;
      resp_ready = 1'b1;
      r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be = '0; r1_pc = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      xact(1'b1, 32'h10,   32'h1234_5678, 4'hF,    32'h0,           1'b0, 0);
      xact(1'b0, 32'h10,   32'h0,         4'h0,    32'h1234_5678,   1'b0, 0);
      xact(1'b1, 32'h10,   32'hAABB_CCDD, 4'b0101, 32'h0,           1'b0, 0);
      xact(1'b0, 32'h10,   32'h0,         4'hF,    32'h12BB_56DD,   1'b0, 0);
      xact(1'b0, 32'h12,   32'h0,         4'hF,    32'h0,           1'b1, 0);
      xact(1'b1, 32'h3000, 32'h1111_1111, 4'hF,    32'h0,           1'b1, 0);
      xact(1'b0, 32'h10,   32'h0,         4'h0,    32'h12BB_56DD,   1'b0, 0);
      xact(1'b1, 32'h14,   32'hFFFF_FFFF, 4'h0,    32'h0,           1'b0, 0);
      xact(1'b0, 32'h14,   32'h0,         4'h0,    32'h0,           1'b0, 0);
      xact(1'b1, 32'h2FFC, 32'hCAFE_F00D, 4'hF,    32'h0,           1'b0, 0);
      xact(1'b0, 32'h2FFC, 32'h0,         4'h0,    32'hCAFE_F00D,   1'b0, 0);
      xact(1'b0, 32'h10,   32'h0,         4'h0,    32'h12BB_56DD,   1'b0, 5);

      // Store accepted, then reset while it is still waiting: it must never commit.
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("midop_in_wait", {31'b0, req_ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("midop_rst_valid", {31'b0, resp_valid}, 32'd0);
      chk("midop_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      xact(1'b0, 32'h20,   32'h0, 4'h0, 32'h0, 1'b0, 0);
      xact(1'b0, 32'h10,   32'h0, 4'h0, 32'h0, 1'b0, 0);
      xact(1'b0, 32'h2FFC, 32'h0, 4'h0, 32'h0, 1'b0, 0);

      // LATENCY=1 instance with request valid held high: one acceptance every 2 cycles.
      set_u1(0);
      r1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("u1_ready", {31'b0, r1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("u1_valid", {31'b0, s1_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i % 2 == 1) begin
            chk("u1_rdata", s1_rdata, exp_u1(i / 2));
            chk("u1_err", {31'b0, s1_err}, 32'd0);
         end
         @(posedge clk); #1;
         if (i % 2 == 0 && i < 6) set_u1(i / 2 + 1);
      end
      r1_valid = 1'b0;

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
